// File: rtl/deadtime_inserter.sv
// Three-phase gate driver with per-phase dead-time insertion between complementary drives.
// Optional latched illegal-pattern fault: define DEADTIME_FAULT_DETECT_EN.
module deadtime_inserter #(
    parameter int K_DEADTIME = 8
) (
    input  logic       i_clk,
    input  logic       i_rst_n,
    input  logic [5:0] i_pattern,
    input  logic       i_enable,
    input  logic       i_fault_clr,
    output logic [2:0] o_gate_h,
    output logic [2:0] o_gate_l,
    output logic [2:0] o_dead,
    output logic       o_fault
);

    localparam int CW = $clog2(K_DEADTIME + 1);
    localparam logic [CW-1:0] C_LAST = CW'(K_DEADTIME - 1);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_DRV_H = 2'd1;
    localparam logic [1:0] S_DRV_L = 2'd2;
    localparam logic [1:0] S_DEAD  = 2'd3;

    logic [1:0]    r_state [3];
    logic [CW-1:0] r_cnt   [3];
    logic          w_block;
    logic [2:0]    w_req_h;
    logic [2:0]    w_req_l;

`ifdef DEADTIME_FAULT_DETECT_EN
    logic r_fault;
    logic w_illegal;

    assign w_illegal = i_enable & (|(i_pattern[5:3] & i_pattern[2:0]));

    // Set has priority over clear.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_fault <= 1'b0;
        end else if (w_illegal) begin
            r_fault <= 1'b1;
        end else if (i_fault_clr) begin
            r_fault <= 1'b0;
        end
    end

    assign w_block = r_fault;
    assign o_fault = r_fault;
`else
    logic w_unused;
    assign w_unused = i_fault_clr;
    assign w_block  = 1'b0;
    assign o_fault  = 1'b0;
`endif

    // ILLEGAL (both bits set) decodes to neither request, i.e. OFF.
    assign w_req_h = {3{i_enable & ~w_block}} & i_pattern[5:3] & ~i_pattern[2:0];
    assign w_req_l = {3{i_enable & ~w_block}} & i_pattern[2:0] & ~i_pattern[5:3];

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            for (int unsigned p = 0; p < 3; p++) begin
                r_state[p] <= S_IDLE;
                r_cnt[p]   <= '0;
            end
        end else begin
            for (int unsigned p = 0; p < 3; p++) begin
                case (r_state[p])
                    S_IDLE: begin
                        if (w_req_h[p]) begin
                            r_state[p] <= S_DRV_H;
                        end else if (w_req_l[p]) begin
                            r_state[p] <= S_DRV_L;
                        end
                    end
                    S_DRV_H: begin
                        if (!w_req_h[p]) begin
                            r_state[p] <= S_DEAD;
                            r_cnt[p]   <= '0;
                        end
                    end
                    S_DRV_L: begin
                        if (!w_req_l[p]) begin
                            r_state[p] <= S_DEAD;
                            r_cnt[p]   <= '0;
                        end
                    end
                    default: begin
                        if (r_cnt[p] != C_LAST) begin
                            r_cnt[p] <= r_cnt[p] + 1'b1;
                        end else if (w_req_h[p]) begin
                            r_state[p] <= S_DRV_H;
                        end else if (w_req_l[p]) begin
                            r_state[p] <= S_DRV_L;
                        end else begin
                            r_state[p] <= S_IDLE;
                        end
                    end
                endcase
            end
        end
    end

    always_comb begin
        o_gate_h = '0;
        o_gate_l = '0;
        o_dead   = '0;
        for (int unsigned p = 0; p < 3; p++) begin
            o_gate_h[p] = (r_state[p] == S_DRV_H);
            o_gate_l[p] = (r_state[p] == S_DRV_L);
            o_dead[p]   = (r_state[p] == S_DEAD);
        end
    end

endmodule

// File: tb/tb_deadtime_inserter.sv
// Directed-vector bench for deadtime_inserter with K_DEADTIME=4.
// Expected vectors are packed as {fault, dead[2:0], gate_h[2:0], gate_l[2:0]}.
module tb_deadtime_inserter;

    logic       i_clk;
    logic       i_rst_n;
    logic [5:0] i_pattern;
    logic       i_enable;
    logic       i_fault_clr;
    logic [2:0] o_gate_h;
    logic [2:0] o_gate_l;
    logic [2:0] o_dead;
    logic       o_fault;

    int n_vec;
    int n_err;

    deadtime_inserter #(.K_DEADTIME(4)) u_dut (
        .i_clk       (i_clk),
        .i_rst_n     (i_rst_n),
        .i_pattern   (i_pattern),
        .i_enable    (i_enable),
        .i_fault_clr (i_fault_clr),
        .o_gate_h    (o_gate_h),
        .o_gate_l    (o_gate_l),
        .o_dead      (o_dead),
        .o_fault     (o_fault)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    task automatic check_vec(input string tag, input logic [9:0] got, input logic [9:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %b, expected %b", tag, got, exp);
        end
    endtask

    task automatic step(input string tag, input logic [5:0] pat, input logic en,
                        input logic clr, input logic [9:0] exp);
        i_pattern   = pat;
        i_enable    = en;
        i_fault_clr = clr;
        @(posedge i_clk);
        #1;
        check_vec(tag, {o_fault, o_dead, o_gate_h, o_gate_l}, exp);
    endtask

    task automatic pulse_reset();
        i_rst_n = 1'b0;
        #2;
        check_vec("reset_async", {o_fault, o_dead, o_gate_h, o_gate_l}, 10'b0);
        i_rst_n = 1'b1;
    endtask

    // Shoot-through guard, sampled mid-cycle.
    always @(negedge i_clk) begin
        if (i_rst_n) check_vec("no_overlap", {7'b0, o_gate_h & o_gate_l}, 10'b0);
    end

    initial begin
        n_vec       = 0;
        n_err       = 0;
        i_rst_n     = 1'b0;
        i_pattern   = 6'b0;
        i_enable    = 1'b1;
        i_fault_clr = 1'b0;
        repeat (2) @(posedge i_clk);
        #1;
        check_vec("in_reset", {o_fault, o_dead, o_gate_h, o_gate_l}, 10'b0);
        i_rst_n = 1'b1;
        step("rst_release", 6'b000000, 1'b1, 1'b0, 10'b0_000_000_000);

        // Idle phases drive straight away.
        step("idle_drive", 6'b100010, 1'b1, 1'b0, 10'b0_000_100_010);
        step("off_dead0",  6'b000000, 1'b1, 1'b0, 10'b0_110_000_000);
        for (int i = 0; i < 3; i++) step("off_dead", 6'b000000, 1'b1, 1'b0, 10'b0_110_000_000);
        step("off_idle",   6'b000000, 1'b1, 1'b0, 10'b0_000_000_000);

        // Low to high: four dead cycles, high from E4.
        step("l_drive",    6'b000001, 1'b1, 1'b0, 10'b0_000_000_001);
        step("l_hold",     6'b000001, 1'b1, 1'b0, 10'b0_000_000_001);
        step("lh_e0",      6'b001000, 1'b1, 1'b0, 10'b0_001_000_000);
        for (int i = 0; i < 3; i++) step("lh_dead", 6'b001000, 1'b1, 1'b0, 10'b0_001_000_000);
        step("lh_e4",      6'b001000, 1'b1, 1'b0, 10'b0_000_001_000);

        // High off, low requested during dead is ignored until interval ends.
        step("h_off",      6'b000000, 1'b1, 1'b0, 10'b0_001_000_000);
        for (int i = 0; i < 3; i++) step("ignore_req", 6'b000001, 1'b1, 1'b0, 10'b0_001_000_000);
        step("to_low",     6'b000001, 1'b1, 1'b0, 10'b0_000_000_001);

        // Same-side return still serves the full interval.
        step("glitch",     6'b000000, 1'b1, 1'b0, 10'b0_001_000_000);
        for (int i = 0; i < 3; i++) step("same_dead", 6'b000001, 1'b1, 1'b0, 10'b0_001_000_000);
        step("same_ret",   6'b000001, 1'b1, 1'b0, 10'b0_000_000_001);

        // Enable drop.
        step("en_drive",   6'b100001, 1'b1, 1'b0, 10'b0_000_100_001);
        step("en_drop",    6'b100001, 1'b0, 1'b0, 10'b0_101_000_000);
        for (int i = 0; i < 3; i++) step("en_dead", 6'b100001, 1'b0, 1'b0, 10'b0_101_000_000);
        step("en_idle",    6'b100001, 1'b0, 1'b0, 10'b0_000_000_000);

        // Reset mid-DEAD: no interval owed afterwards.
        step("pre_rst_l",  6'b000001, 1'b1, 1'b0, 10'b0_000_000_001);
        step("pre_rst_d",  6'b000000, 1'b1, 1'b0, 10'b0_001_000_000);
        pulse_reset();
        step("post_rst_h", 6'b001000, 1'b1, 1'b0, 10'b0_000_001_000);
        // Reset mid-drive.
        pulse_reset();
        step("post_rst_l", 6'b000001, 1'b1, 1'b0, 10'b0_000_000_001);

        // Illegal pattern while phase 1 drives.
        pulse_reset();
        step("p1_low",     6'b000010, 1'b1, 1'b0, 10'b0_000_000_010);
`ifdef DEADTIME_FAULT_DETECT_EN
        step("fault_set",  6'b001001, 1'b1, 1'b0, 10'b1_010_000_000);
        step("fault_clr",  6'b000010, 1'b1, 1'b1, 10'b0_010_000_000);
`else
        step("illegal_off", 6'b001001, 1'b1, 1'b0, 10'b0_010_000_000);
        step("no_latch",   6'b000010, 1'b1, 1'b1, 10'b0_010_000_000);
`endif
        step("p1_dead2",   6'b000010, 1'b1, 1'b0, 10'b0_010_000_000);
        step("p1_dead3",   6'b000010, 1'b1, 1'b0, 10'b0_010_000_000);
        step("p1_return",  6'b000010, 1'b1, 1'b0, 10'b0_000_000_010);

`ifdef DEADTIME_FAULT_DETECT_EN
        // Set beats clear; latched fault blocks a HIGH request until cleared.
        step("set_wins",   6'b001001, 1'b1, 1'b1, 10'b1_010_000_000);
        step("fault_blk",  6'b001000, 1'b1, 1'b0, 10'b1_010_000_000);
        step("clr_edge",   6'b001000, 1'b1, 1'b1, 10'b0_010_000_000);
        step("after_clr",  6'b001000, 1'b1, 1'b0, 10'b0_010_001_000);
        step("p1_idle",    6'b001000, 1'b1, 1'b0, 10'b0_000_001_000);
`else
        step("ill_clr",    6'b001001, 1'b1, 1'b1, 10'b0_010_000_000);
        step("no_blk",     6'b001000, 1'b1, 1'b0, 10'b0_010_001_000);
        step("no_blk2",    6'b001000, 1'b1, 1'b1, 10'b0_010_001_000);
        step("no_blk3",    6'b001000, 1'b1, 1'b0, 10'b0_010_001_000);
        step("p1_idle",    6'b001000, 1'b1, 1'b0, 10'b0_000_001_000);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/deadtime_inserter.md
DEADTIME_INSERTER -- requirements
Module: deadtime_inserter

Interface
REQ-001 Parameter K_DEADTIME, default 8: dead interval in i_clk cycles; legal range 1..255.
REQ-002 i_clk  input  1  main clock; all logic on rising edge.
REQ-003 i_rst_n  input  1  asynchronous active-low reset.
REQ-004 i_pattern  input  6  requested motor pattern; bit [3+p] is phase p high side, bit [p] is phase p low side, p=0..2.
REQ-005 i_enable  input  1  when 0, every phase is requested OFF.
REQ-006 i_fault_clr  input  1  clears the latched fault.
REQ-007 o_gate_h  output  3  high-side gate drive, one bit per phase, registered.
REQ-008 o_gate_l  output  3  low-side gate drive, one bit per phase, registered.
REQ-009 o_dead  output  3  per phase, 1 while that phase is in DEAD.
REQ-010 o_fault  output  1  latched illegal-pattern flag.

Function
REQ-011 Per-phase request decoding: {h,l}=10 is HIGH, 01 is LOW, 00 is OFF, 11 is ILLEGAL and is treated as OFF; i_enable=0 forces OFF for all phases.
REQ-012 Each phase has an independent FSM with states IDLE, DRV_H, DRV_L and DEAD, plus a dead counter of width $clog2(K_DEADTIME+1).
REQ-013 IDLE transitions: HIGH to DRV_H; LOW to DRV_L; OFF stays in IDLE.
REQ-014 DRV_H transitions: HIGH stays in DRV_H; any other request goes to DEAD with the counter loaded to 0. DRV_L is symmetric.
REQ-015 DEAD, counter != K_DEADTIME-1: increment the counter and ignore the request.
REQ-016 DEAD, counter == K_DEADTIME-1: go to DRV_H on HIGH, DRV_L on LOW, IDLE on OFF.
REQ-017 A phase that leaves DEAD for a drive state always serves the full dead interval, even when returning to the side it left.
REQ-018 Output decoding: o_gate_h[p] = (state==DRV_H); o_gate_l[p] = (state==DRV_L); o_dead[p] = (state==DEAD).
REQ-019 Latency: a request change on one clock edge is visible on the outputs after that same edge (1 cycle from input sampling).
REQ-020 Turn-off is never delayed.
REQ-021 Between complementary drives, both gates of a phase are low for exactly K_DEADTIME cycles.
REQ-022 o_gate_h[p] and o_gate_l[p] are never both 1 in any cycle.

Reset
REQ-023 While i_rst_n=0, all FSMs are IDLE, all counters are 0, and o_gate_h=0, o_gate_l=0, o_dead=0, o_fault=0.
REQ-024 Reset asserted mid-DEAD or mid-drive clears the phase immediately; after release the phase starts from IDLE with no dead interval owed.

Configuration
REQ-025 With macro DEADTIME_FAULT_DETECT_EN defined, ILLEGAL on any phase while i_enable=1 sets o_fault on the next edge.
REQ-026 With DEADTIME_FAULT_DETECT_EN defined, o_fault=1 forces every phase's request to OFF until o_fault clears.
REQ-027 With DEADTIME_FAULT_DETECT_EN defined, i_fault_clr=1 clears o_fault on the next edge; a simultaneous set condition wins over clear.
REQ-028 Without DEADTIME_FAULT_DETECT_EN, o_fault is constant 0, ILLEGAL is treated only as OFF, and nothing is latched.

Verification (K_DEADTIME=4)
REQ-029 Reset release, i_pattern=000000 -> o_gate_h=000, o_gate_l=000, o_dead=000, o_fault=0.
REQ-030 IDLE phases, i_pattern=100010 -> one edge later o_gate_h=100 and o_gate_l=010, with no dead interval.
REQ-031 i_pattern held at 000001, then 001000 at edge E0 -> o_gate_l[0]=0 and o_dead[0]=1 from E0; o_gate_h[0]=1 from E4; both gates low for 4 cycles.
REQ-032 DRV_L phase 0, i_pattern 000000 for 1 cycle then back to 000001 -> o_gate_l[0] is low for exactly 4 cycles before reasserting.
REQ-033 Macro defined, i_pattern=001001 (phase 0 ILLEGAL) while phase 1 is driving -> o_fault=1 next edge and all gates off; i_fault_clr=1 with i_pattern=000010 -> o_fault=0 next edge; phase 1 low side returns after its dead interval.
REQ-034 i_enable dropped to 0 while i_pattern=100001 -> all gates 0 next edge and o_dead=101 for 4 cycles, then 000.
